// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// Optional grant locking is built only when ARB_LOCK_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] ain0,
    input  logic [63:0] ain1,
    input  logic [63:0] din0,
    input  logic [63:0] din1,
    input  logic        wren0,
    input  logic        wren1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [63:0] rdata0,
    output logic [63:0] rdata1,
    output logic [63:0] mem_ain,
    output logic [63:0] mem_din,
    output logic        mem_wren,
    input  logic [63:0] mem_dout
);

    logic       last_q, last_d;
    logic [1:0] pend_q, pend_d;  // {valid, owner}
    logic       gnt_any;
    logic       win;
    logic       win_wren;

`ifdef ARB_LOCK_EN
    logic       lk_vld_q, lk_vld_d;
    logic       lk_own_q, lk_own_d;
    logic [3:0] lk_cnt_q, lk_cnt_d;
    logic       lk_force;
    logic       lk_refuse;
    logic       win_lock;

    always_comb begin
        lk_force  = lk_vld_q && (lk_own_q ? req1 : req0);
        // The lock is refused only when the streak is full and the other side waits.
        lk_refuse = (lk_cnt_q >= 4'(MAX_LOCK)) && (lk_own_q ? req0 : req1);
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    always_comb begin
        gnt_any = !rst && (req0 || req1);
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
`ifdef ARB_LOCK_EN
        if (lk_force) begin
            win = lk_refuse ? ~lk_own_q : lk_own_q;
        end
`endif
    end

    always_comb begin
        gnt0     = gnt_any && !win;
        gnt1     = gnt_any && win;
        win_wren = win ? wren1 : wren0;
        mem_ain  = gnt_any ? (win ? ain1 : ain0) : 64'd0;
        mem_din  = gnt_any ? (win ? din1 : din0) : 64'd0;
        mem_wren = gnt_any && win_wren;
        last_d   = gnt_any ? win : last_q;
        pend_d   = {gnt_any && !win_wren, win};
    end

    always_comb begin
        rvalid0 = !rst && pend_q[1] && !pend_q[0];
        rvalid1 = !rst && pend_q[1] && pend_q[0];
        rdata0  = rvalid0 ? mem_dout : 64'd0;
        rdata1  = rvalid1 ? mem_dout : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
            pend_q <= 2'b00;
        end else begin
            last_q <= last_d;
            pend_q <= pend_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_comb begin
        win_lock = win ? lock1 : lock0;
        lk_vld_d = gnt_any && win_lock;
        lk_own_d = win;
        lk_cnt_d = 4'd0;
        if (gnt_any && win_lock) begin
            if (lk_vld_q && (lk_own_q == win)) begin
                lk_cnt_d = (lk_cnt_q == 4'hF) ? 4'hF : lk_cnt_q + 4'd1;
            end else begin
                lk_cnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_vld_q <= 1'b0;
            lk_own_q <= 1'b0;
            lk_cnt_q <= 4'd0;
        end else begin
            lk_vld_q <= lk_vld_d;
            lk_own_q <= lk_own_d;
            lk_cnt_q <= lk_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int MaxLock = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wren0, wren1, lock0, lock1;
    logic [63:0] ain0, ain1, din0, din1, mem_dout;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren;
    logic [63:0] rdata0, rdata1, mem_ain, mem_din;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic m_last, m_pv, m_po, m_lkv, m_lko;
    int   m_cnt;
    logic s_g, s_w;      // last cycle's expected grant / winner
    logic s_gnt0, s_gnt1;
    logic s_rv0, s_rv1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_LOCK(MaxLock)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .ain0(ain0), .ain1(ain1),
        .din0(din0), .din1(din1), .wren0(wren0), .wren1(wren1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_ain(mem_ain), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict, check at negedge, advance model at posedge.
    task automatic tick();
        logic eg, ew, ewr, elk;
        logic [63:0] ea, ed;
        eg = !rst && (req0 || req1);
        if (req0 && req1) begin
            ew = !m_last;
`ifdef ARB_LOCK_EN
            if (m_lkv) ew = (m_cnt >= MaxLock) ? !m_lko : m_lko;
`endif
        end else begin
            ew = req1;
        end
        ea  = eg ? (ew ? ain1 : ain0) : 64'd0;
        ed  = eg ? (ew ? din1 : din0) : 64'd0;
        ewr = eg && (ew ? wren1 : wren0);
        elk = ew ? lock1 : lock0;
        @(negedge clk);
        check("gnt0", gnt0, eg && !ew);
        check("gnt1", gnt1, eg && ew);
        check("mem_ain", mem_ain, ea);
        check("mem_din", mem_din, ed);
        check("mem_wren", mem_wren, ewr);
        check("rvalid0", rvalid0, !rst && m_pv && !m_po);
        check("rvalid1", rvalid1, !rst && m_pv && m_po);
        check("rdata0", rdata0, (!rst && m_pv && !m_po) ? mem_dout : 64'd0);
        check("rdata1", rdata1, (!rst && m_pv && m_po) ? mem_dout : 64'd0);
        s_gnt0 = gnt0;
        s_gnt1 = gnt1;
        s_rv0  = rvalid0;
        s_rv1  = rvalid1;
        s_g    = eg;
        s_w    = ew;
        @(posedge clk);
        if (rst) begin
            m_last = 1'b1; m_pv = 1'b0; m_po = 1'b0;
            m_lkv = 1'b0; m_lko = 1'b0; m_cnt = 0;
        end else begin
            m_pv = eg && !ewr;
            m_po = ew;
            if (eg) m_last = ew;
            if (eg && elk) begin
                m_cnt = (m_lkv && m_lko == ew) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
                m_lkv = 1'b1;
                m_lko = ew;
            end else begin
                m_cnt = 0;
                m_lkv = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [5:0] hist;
        logic [5:0] hist_exp;
        m_last = 1'b1; m_pv = 1'b0; m_po = 1'b0; m_lkv = 1'b0; m_lko = 1'b0; m_cnt = 0;
        rst = 1'b1;
        req0 = 0; req1 = 0; wren0 = 0; wren1 = 0; lock0 = 0; lock1 = 0;
        ain0 = 0; ain1 = 0; din0 = 0; din1 = 0; mem_dout = 64'h1234;
        @(posedge clk);
        #1;
        // Reset: all outputs forced low even with requests present
        req0 = 1; req1 = 1; wren0 = 1;
        tick();
        tick();
        rst = 0; req0 = 0; req1 = 0; wren0 = 0;

        // Single read
        req0 = 1; ain0 = 64'h40;
        tick();
        check("single_gnt0", s_gnt0, 1'b1);
        req0 = 0; mem_dout = 64'hDEAD_BEEF;
        tick();
        check("single_rvalid0", s_rv0, 1'b1);
        check("single_rvalid1", s_rv1, 1'b0);

        // Contention from reset, requester 0 asking for lock
        rst = 1;
        tick();
        rst = 0;
        req0 = 1; req1 = 1; ain0 = 64'h100; ain1 = 64'h200;
        din0 = 64'hA0; din1 = 64'hB1; wren0 = 1; wren1 = 0; lock0 = 1;
        for (int i = 0; i < 6; i++) begin
            mem_dout = {$urandom, $urandom};
            tick();
            hist[i] = s_gnt1;
        end
`ifdef ARB_LOCK_EN
        hist_exp = 6'b010000;
`else
        hist_exp = 6'b101010;
`endif
        check("contention_seq", {58'd0, hist}, {58'd0, hist_exp});

        // Write then read by requester 1
        req0 = 0; lock0 = 0; wren0 = 0;
        req1 = 1; ain1 = 64'h2000_0000_0000_0008; din1 = 64'h55; wren1 = 1;
        tick();
        wren1 = 0;
        tick();
        check("wr_rd_no_early_rvalid", s_rv1, 1'b0);
        req1 = 0; mem_dout = 64'hCAFE;
        tick();
        check("wr_rd_rvalid1", s_rv1, 1'b1);

        // Idle port
        tick();
        tick();

        // Reset during an in-flight read
        req0 = 1; ain0 = 64'h80; wren0 = 0;
        tick();
        rst = 1; req0 = 0;
        tick();
        check("rst_mid_rvalid_t1", s_rv0, 1'b0);
        rst = 0;
        tick();
        check("rst_mid_rvalid_t2", s_rv0, 1'b0);
        req0 = 1; req1 = 1;
        tick();
        check("rst_first_contention", s_gnt0, 1'b1);

        // Randomized traffic; a losing requester holds its request
        for (int n = 0; n < 400; n++) begin
            if (!(req0 && !(s_g && !s_w)) || rst) begin
                req0 = ($urandom_range(0, 3) != 0); ain0 = {$urandom, $urandom};
                din0 = {$urandom, $urandom}; wren0 = $urandom_range(0, 1) != 0;
            end
            if (!(req1 && !(s_g && s_w)) || rst) begin
                req1 = ($urandom_range(0, 3) != 0); ain1 = {$urandom, $urandom};
                din1 = {$urandom, $urandom}; wren1 = $urandom_range(0, 1) != 0;
            end
            lock0 = $urandom_range(0, 3) != 0;
            lock1 = $urandom_range(0, 3) == 0;
            rst = ($urandom_range(0, 39) == 0);
            mem_dout = {$urandom, $urandom};
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single CPU-side memory port of the region address decoder between requester 0 (CPU pipeline) and requester 1 (performance/DMA engine). It picks one requester per cycle with round-robin fairness and drives the winner's address, data and write enable onto the shared port. It returns read data to the issuing requester with the decoder's one-cycle read latency. It sits between the requesters and the decoder's cpu_ain/cpu_din/cpu_wren/cpu_dout side.

## Interface
- MAX_LOCK, 4: maximum consecutive locked grants to one requester while the other is waiting (1..15).
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held with its address/data until the cycle gnt is high.
- ain0 / ain1  in  64  byte address.
- din0 / din1  in  64  write data.
- wren0 / wren1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  request to keep the grant on the next cycle; used only with ARB_LOCK_EN.
- gnt0 / gnt1  out  1  combinational grant; the access is performed in this cycle.
- rvalid0 / rvalid1  out  1  read data valid for that requester.
- rdata0 / rdata1  out  64  read data, valid when rvalid is high, 0 otherwise.
- mem_ain  out  64  shared port address.
- mem_din  out  64  shared port write data.
- mem_wren  out  1  shared port write enable.
- mem_dout  in  64  shared port read data, valid one cycle after the read address.

## Operation
- gnt0 and gnt1 are never high in the same cycle. gnt_i is never high unless req_i is high.
- Round-robin state is a 1-bit register `last`, holding the most recently granted requester. Reset value is 1, so requester 0 wins the first contention.
- Only one request present: that requester is granted.
- Both requests present and no lock in force: grant goes to the requester that is not `last`.
- `last` updates to the granted index on every granted cycle. It holds when nothing is granted.
- Port drive:
  - With a grant: mem_ain, mem_din and mem_wren equal the winner's ain, din and wren.
  - With no grant: all three are 0.
- Read tracking: a 2-bit register `pend` = {valid, owner} is set on each granted read and cleared otherwise. Granted writes produce no response.
- When pend.valid is high: rvalid[owner] = 1 and rdata[owner] = mem_dout. The other requester's rvalid and rdata are 0.
- Back-to-back reads by either requester are fully pipelined, one per cycle.
- The other requester is never granted for two consecutive cycles while one requester is waiting, except under a lock.

## Timing
- Grant latency is 0 cycles: req_i at cycle t gives gnt_i at t if it wins. The access is presented on the port at t.
- Read response: rvalid_i and rdata_i at t+1. Write latency is 0; the write commits at t.
- A requester that loses arbitration holds req/ain/din/wren stable. Worst-case wait is 1 cycle without lock, or MAX_LOCK cycles with lock.
- Reset values: last=1, pend=0, lock counter=0.
- Output values while rst is high: gnt*=0, rvalid*=0, rdata*=0, mem_*=0.
- Reset while a read is in flight (rst at t+1 after a read at t): that response is dropped and no rvalid is produced.
- A requester that drops req between cycles is ignored. There is no cancellation of a read already granted.

## Configuration
- ARB_LOCK_EN defined:
  - If the requester granted at t had lock_i=1 and still has req_i=1 at t+1, it is granted again regardless of the other request.
  - A 4-bit counter counts consecutive locked grants.
  - When the count reaches MAX_LOCK and the other requester is requesting, the lock is refused for one cycle and the other requester is granted.
  - The counter clears when ownership changes, when req drops, or when lock is 0.
- ARB_LOCK_EN undefined: lock0/lock1 are ignored, no counter is built, and arbitration is pure round-robin.

## Test plan
- Single read: req0=1, ain0=0x0000_0000_0000_0040, wren0=0; mem_dout=0xDEAD_BEEF at t+1 -> gnt0=1 at t, mem_ain=0x40, rvalid0=1 and rdata0=0xDEAD_BEEF at t+1, rvalid1=0.
- Contention from reset: req0=req1=1 held for 4 cycles -> grants 0,1,0,1, and mem_wren/mem_ain follow the winner each cycle.
- Write then read pipeline: req1 write 0x55 to 0x2000_0000_0000_0008 at t, then read same address at t+1 -> mem_wren=1,0. rvalid1 only at t+2. No rvalid at t+1.
- Idle port: req0=req1=0 -> mem_ain=mem_din=0, mem_wren=0, gnt*=0, and `last` unchanged.
- Reset mid-read: granted read at t, rst=1 at t+1 -> rvalid0=0 at t+1 and t+2. After release, the first contention grants requester 0.
- ARB_LOCK_EN, MAX_LOCK=4: req0=lock0=1 and req1=1 continuously -> gnt0 for 4 cycles, gnt1 for the 5th, then gnt0 again. Without the macro -> strict alternation.
